// File: rtl/ram8_pkg.sv
// Shared definitions for the ram8_ctrl register memory: geometry, FSM states and parity helper.
package ram8_pkg;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned PAR_MAX_W = 64;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_t;

    // Even-parity bit: callers zero-extend their word to PAR_MAX_W, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/decoder.sv
// 3-to-8 one-hot decoder feeding the per-word load enables of ram8_ctrl.
module decoder
    import ram8_pkg::*;
(
    input  logic [ADDR_W-1:0] sel,
    output logic [DEPTH-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/ram8_ctrl.sv
// 8-word register memory with valid/ready request port, registered read response and clear sweep.
// Optional per-word even parity is enabled by defining RAM8_CTRL_PARITY_EN.
module ram8_ctrl
    import ram8_pkg::*;
#(
    parameter int unsigned     WIDTH     = 16,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_perr,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              rsp_valid_q;
    logic [WIDTH-1:0]  rsp_rdata_q;

    logic              accept;
    logic              wr_en;
    logic              rd_accept;
    logic [ADDR_W-1:0] dec_sel;
    logic [DEPTH-1:0]  dec_onehot;
    logic [DEPTH-1:0]  load_en;
    logic [WIDTH-1:0]  wdata;

    assign req_ready = (state_q == StIdle) && !clr_start && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign wr_en     = (state_q == StClear) || (accept && req_we);
    assign dec_sel   = (state_q == StClear) ? cnt_q : req_addr;
    assign wdata     = (state_q == StClear) ? CLR_VALUE : req_wdata;
    assign load_en   = dec_onehot & {DEPTH{wr_en}};

    decoder u_decoder (
        .sel    (dec_sel),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr_start) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    // done is raised one edge early so it coincides with the last sweep write
                    done_q <= (cnt_q == LastWord - ADDR_W'(1));
                    if (cnt_q == LastWord) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_q[i] <= '0;
            end else if (load_en[i]) begin
                mem_q[i] <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (rd_accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= mem_q[req_addr];
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef RAM8_CTRL_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             rsp_perr_q;
    logic             wpar;
    logic             rd_perr;

    assign wpar    = even_parity(PAR_MAX_W'(wdata));
    assign rd_perr = par_q[req_addr] ^ even_parity(PAR_MAX_W'(mem_q[req_addr]));

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                par_q[i] <= 1'b0;
            end else if (load_en[i]) begin
                par_q[i] <= wpar;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_perr_q <= 1'b0;
        end else if (rd_accept) begin
            rsp_perr_q <= rd_perr;
        end
    end

    assign rsp_perr = rsp_perr_q;
`else
    assign rsp_perr = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign clr_busy  = busy_q;
    assign clr_done  = done_q;

endmodule

// File: tb/tb_ram8_ctrl.sv
// Randomized plus directed bench for ram8_ctrl against an array-based behavioural model.
module tb_ram8_ctrl;

    localparam logic [15:0] CLR = 16'h00FF;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_perr;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;

    ram8_ctrl #(
        .WIDTH     (16),
        .CLR_VALUE (CLR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_perr  (rsp_perr),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: plain memory array, sweep index (-1 when idle), pending response.
    logic [15:0] m_mem [8];
    logic [7:0]  m_bad = '0;
    int          sweep = -1;
    logic        e_valid = 1'b0;
    logic [15:0] e_rdata = '0;
    logic        e_perr = 1'b0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin : model
        logic acc;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
            m_bad   = '0;
            sweep   = -1;
            e_valid = 1'b0;
            e_rdata = '0;
            e_perr  = 1'b0;
        end else begin
            acc = req_valid && (sweep < 0) && !clr_start && (!e_valid || rsp_ready);
            if (acc && !req_we) begin
                e_valid = 1'b1;
                e_rdata = m_mem[req_addr];
                e_perr  = m_bad[req_addr];
            end else if (e_valid && rsp_ready) begin
                e_valid = 1'b0;
            end
            if (acc && req_we) begin
                m_mem[req_addr] = req_wdata;
                m_bad[req_addr] = 1'b0;
            end
            if (sweep >= 0) begin
                m_mem[sweep] = CLR;
                m_bad[sweep] = 1'b0;
                sweep = (sweep == 7) ? -1 : sweep + 1;
            end else if (clr_start) begin
                sweep = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk1("req_ready", req_ready,
                 (sweep < 0) && !clr_start && (!e_valid || rsp_ready));
            chk1("rsp_valid", rsp_valid, e_valid);
            chk1("clr_busy", clr_busy, sweep >= 0);
            chk1("clr_done", clr_done, sweep == 7);
            if (e_valid) begin
                chk16("rsp_rdata", rsp_rdata, e_rdata);
                chk1("rsp_perr", rsp_perr, e_perr);
            end
        end
    end

    task automatic step(input logic v, input logic we, input logic [2:0] a, input logic [15:0] d,
                        input logic rr, input logic cs, input logic rst);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        clr_start = cs;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk16("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk1("rst_rsp_perr", rsp_perr, 1'b0);
        chk1("rst_clr_busy", clr_busy, 1'b0);
        chk1("rst_clr_done", clr_done, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);

        // write then immediate read of the same word
        step(1'b1, 1'b1, 3'd5, 16'h1234, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd5, 16'h0, 1'b1, 1'b0, 1'b0);
        chk1("wr_rd_valid", rsp_valid, 1'b1);
        chk16("wr_rd_data", rsp_rdata, 16'h1234);
        for (int i = 0; i < 8; i++) begin
            if (i != 5) begin
                step(1'b1, 1'b0, 3'(i), 16'h0, 1'b1, 1'b0, 1'b0);
                chk16("other_zero", rsp_rdata, 16'h0000);
            end
        end
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);

        // fill and back-to-back reads
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 16'hA000 + 16'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'(i), 16'h0, 1'b1, 1'b0, 1'b0);
            chk1("b2b_valid", rsp_valid, 1'b1);
            chk16("b2b_data", rsp_rdata, 16'hA000 + 16'(i));
        end
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);

        // stalled response holds and blocks new requests
        step(1'b1, 1'b0, 3'd3, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 3'd6, 16'h0, 1'b0, 1'b0, 1'b0);
            chk1("stall_ready", req_ready, 1'b0);
            chk16("stall_data", rsp_rdata, 16'hA003);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk1("stall_release_ready", req_ready, 1'b1);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk1("stall_drained", rsp_valid, 1'b0);

        // clear sweep beats a simultaneous write
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd0; req_wdata = 16'h5555;
        clr_start = 1'b1;
        #1;
        chk1("clr_blocks_req", req_ready, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            chk1("sweep_busy", clr_busy, 1'b1);
            chk1("sweep_done", clr_done, k == 7);
            step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        end
        chk1("sweep_idle", clr_busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'(i), 16'h0, 1'b1, 1'b0, 1'b0);
            chk16("clr_value", rsp_rdata, CLR);
        end
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);

        // reset aborts a sweep in its fourth cycle
        step(1'b1, 1'b1, 3'd1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk1("abort_busy", clr_busy, 1'b0);
        chk1("abort_done", clr_done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'(i), 16'h0, 1'b1, 1'b0, 1'b0);
            chk16("abort_zero", rsp_rdata, 16'h0000);
        end
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);

`ifdef RAM8_CTRL_PARITY_EN
        step(1'b1, 1'b1, 3'd2, 16'h0001, 1'b1, 1'b0, 1'b0);
        force dut.par_q[2] = 1'b0;
        m_bad[2] = 1'b1;
        step(1'b1, 1'b0, 3'd2, 16'h0, 1'b1, 1'b0, 1'b0);
        chk1("perr_flagged", rsp_perr, 1'b1);
        release dut.par_q[2];
        step(1'b1, 1'b0, 3'd4, 16'h0, 1'b1, 1'b0, 1'b0);
        chk1("perr_clean", rsp_perr, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 4) != 0, 1'($urandom % 2), 3'($urandom % 8), 16'($urandom),
                 ($urandom % 4) != 0, ($urandom % 50) == 0, ($urandom % 400) == 0);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
